// File: rtl/loadable_down_counter.sv
// Loadable binary down-counter / timer.
// A load captures a start value into both the counter and a reload register. While running
// and enabled, the counter decrements to zero and emits a one-cycle terminal-count pulse.
// With auto_reload set at the terminal edge, it restarts from the reload register, which
// gives periodic ticks.
module loadable_down_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic             load,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc
);

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    localparam logic [WIDTH-1:0] Zero = '0;
    localparam logic [WIDTH-1:0] One  = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    // Next-state logic. Priority is load over enable; tc is a pulse and defaults low.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (load) begin
            // A load never decrements in the same cycle. A zero load leaves the timer idle.
            count_d  = d;
            reload_d = d;
            state_d  = (d != Zero) ? StRun : StIdle;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (en) begin
                        if (count_q == One) begin
                            tc_d = 1'b1;
                            if (auto_reload && (reload_q != Zero)) begin
                                count_d = reload_q;
                            end else begin
                                count_d = Zero;
                                state_d = StIdle;
                            end
                        end else if (count_q == Zero) begin
                            // Unreachable in normal operation. Park safely rather than underflow.
                            state_d = StIdle;
                        end else begin
                            count_d = count_q - One;
                        end
                    end
                end
                StIdle: begin
                    // Enable is ignored while idle and the count holds.
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State register with asynchronous clear. A reset mid-run aborts without a tc pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            count_q  <= Zero;
            reload_q <= Zero;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    // Every output comes directly from a register.
    always_comb begin
        count = count_q;
        busy  = (state_q == StRun);
        tc    = tc_q;
    end

endmodule

// File: tb/tb_loadable_down_counter.sv
// Directed bench for loadable_down_counter. A behavioural model follows the timer rules.
// A compare process checks every output on every cycle, and literal expectations pin both
// the model and the DUT at key points.
module tb_loadable_down_counter;

    logic       clk;
    logic       reset;
    logic [3:0] d;
    logic       load;
    logic       en;
    logic       auto_reload;
    logic [3:0] count;
    logic       busy;
    logic       tc;

    int tests = 0;
    int fails = 0;

    // Model state: remaining count, stored start value, running flag, pulse.
    int m_count  = 0;
    int m_reload = 0;
    bit m_run    = 0;
    bit m_tc     = 0;

    loadable_down_counter #(.WIDTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .d          (d),
        .load       (load),
        .en         (en),
        .auto_reload(auto_reload),
        .count      (count),
        .busy       (busy),
        .tc         (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the timer. Inputs are stable at posedge because they change at negedge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_count = 0; m_reload = 0; m_run = 0; m_tc = 0;
        end else if (load) begin
            m_count = int'(d); m_reload = int'(d); m_run = (d != 0); m_tc = 0;
        end else if (m_run && en) begin
            if (m_count == 1) begin
                m_tc = 1;
                if (auto_reload && m_reload != 0) m_count = m_reload;
                else begin m_count = 0; m_run = 0; end
            end else begin
                m_count = m_count - 1;
                m_tc = 0;
            end
        end else begin
            m_tc = 0;
        end
    end

    // Every-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            check("cmp_count", 32'(count), 32'(m_count));
            check("cmp_busy", 32'(busy), 32'(m_run));
            check("cmp_tc", 32'(tc), 32'(m_tc));
        end
    end

    task automatic cyc(input logic l, input logic [3:0] dv, input logic e, input logic ar);
        @(negedge clk);
        load = l; d = dv; en = e; auto_reload = ar;
        @(posedge clk);
        #2;
    endtask

    task automatic expect3(input string name, input int c, input bit b, input bit t);
        check({name, "_count"}, 32'(count), 32'(c));
        check({name, "_busy"}, 32'(busy), 32'(b));
        check({name, "_tc"}, 32'(tc), 32'(t));
    endtask

    // Bound the run in case something stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; load = 1'b0; d = 4'd0; en = 1'b0; auto_reload = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        expect3("reset", 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // 1: one-shot from 3.
        cyc(1, 4'd3, 1, 0); expect3("t1_load", 3, 1, 0);
        cyc(0, 4'd0, 1, 0); expect3("t1_c2", 2, 1, 0);
        cyc(0, 4'd0, 1, 0); expect3("t1_c1", 1, 1, 0);
        cyc(0, 4'd0, 1, 0); expect3("t1_term", 0, 0, 1);
        cyc(0, 4'd0, 1, 0); expect3("t1_after", 0, 0, 0);

        // 2: periodic reload from 2.
        cyc(1, 4'd2, 1, 1); expect3("t2_load", 2, 1, 0);
        cyc(0, 4'd0, 1, 1); expect3("t2_c1", 1, 1, 0);
        cyc(0, 4'd0, 1, 1); expect3("t2_rl1", 2, 1, 1);
        cyc(0, 4'd0, 1, 1); expect3("t2_c1b", 1, 1, 0);
        cyc(0, 4'd0, 1, 1); expect3("t2_rl2", 2, 1, 1);

        // 3: hold with en=0.
        cyc(1, 4'd5, 0, 0); expect3("t3_load", 5, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 4'd0, 0, 0); expect3("t3_hold", 5, 1, 0);
        end
        cyc(0, 4'd0, 1, 0); expect3("t3_c4", 4, 1, 0);
        cyc(0, 4'd0, 1, 0); expect3("t3_c3", 3, 1, 0);

        // 4: load coincident with the terminal edge.
        cyc(0, 4'd0, 1, 0); expect3("t4_c2", 2, 1, 0);
        cyc(0, 4'd0, 1, 0); expect3("t4_c1", 1, 1, 0);
        cyc(1, 4'd9, 1, 0); expect3("t4_loadwin", 9, 1, 0);

        // 5: asynchronous reset between edges aborts the run.
        cyc(1, 4'd7, 1, 0); expect3("t5_load", 7, 1, 0);
        cyc(0, 4'd0, 1, 0); expect3("t5_c6", 6, 1, 0);
        cyc(0, 4'd0, 1, 0); expect3("t5_c5", 5, 1, 0);
        #1 reset = 1'b1;
        #1 expect3("t5_async", 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        cyc(0, 4'd0, 1, 0); expect3("t5_post", 0, 0, 0);

        // 6: zero load, then a full-range countdown with no underflow.
        cyc(1, 4'd0, 1, 0); expect3("t6_zero", 0, 0, 0);
        cyc(1, 4'hF, 1, 0); expect3("t6_load", 15, 1, 0);
        for (int i = 0; i < 15; i++) begin
            cyc(0, 4'd0, 1, 0);
            expect3("t6_run", 14 - i, (i != 14), (i == 14));
        end
        cyc(0, 4'd0, 1, 0); expect3("t6_stay", 0, 0, 0);
        cyc(0, 4'd0, 1, 0); expect3("t6_stay2", 0, 0, 0);

        // Reload value of 1 with auto_reload produces tc every cycle.
        cyc(1, 4'd1, 1, 1); expect3("r1_load", 1, 1, 0);
        cyc(0, 4'd0, 1, 1); expect3("r1_tc1", 1, 1, 1);
        cyc(0, 4'd0, 1, 1); expect3("r1_tc2", 1, 1, 1);

        // auto_reload dropped mid-run takes effect at the terminal edge.
        cyc(1, 4'd2, 1, 1); expect3("ar_load", 2, 1, 0);
        cyc(0, 4'd0, 1, 0); expect3("ar_c1", 1, 1, 0);
        cyc(0, 4'd0, 1, 0); expect3("ar_stop", 0, 0, 1);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
